// File: rtl/narnet_seq_ctrl.sv
// Sequencer between a host sample stream, a NAR prediction core and a
// prediction output stream. Supports open-loop (one host sample per
// prediction) and closed-loop (seed, then feed predictions back) runs,
// with a watchdog that aborts a step when the core never answers.
//
// state | meaning
// IDLE  | waiting for enable and a settled FIFO head; pops it into x_reg
// ISSUE | presents x_reg to the core with a one-cycle strobe
// WAIT  | watchdog running, waiting for the core done pulse
// EMIT  | holds the captured prediction on the output stream until taken
// ERR   | watchdog expired: pulses core_rst, drops the rest of the run
module narnet_seq_ctrl #(
    parameter int N          = 10,
    parameter int Q          = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         mode,
    input  logic [7:0]   horizon,
    input  logic         s_valid,
    input  logic [N-1:0] s_data,
    output logic         s_ready,
    output logic         core_enable,
    output logic         core_rst,
    output logic [N-1:0] core_x,
    output logic         core_x_ready,
    input  logic [N-1:0] core_y,
    input  logic         core_out_ready,
    output logic         m_valid,
    output logic [N-1:0] m_data,
    output logic         m_last,
    input  logic         m_ready,
    output logic         busy,
    output logic         timeout_err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    // Q only documents the fixed-point format; reject nonsensical parameter sets.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || Q > N) begin : g_param_check
        $error("narnet_seq_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and Q <= N");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, ERR} state_t;

    state_t         state, state_next;
    logic [N-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, count_next;
    logic           head_settled;
    logic           push, pop, err_pulse;
    logic [N-1:0]   x_reg, y_reg;
    logic [7:0]     steps_left;
    logic [WDW-1:0] watchdog;
    logic           mode_run;

    assign push        = s_valid && s_ready;
    assign count_next  = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign core_enable = enable;
    assign core_rst    = rst | err_pulse;
    assign core_x      = x_reg;
    assign m_data      = y_reg;
    assign busy        = (state != IDLE);

    // FIFO storage; emptiness is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and flags; head_settled lags occupancy by one cycle so a
    // freshly written entry is never read on its write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            s_ready      <= 1'b0;
            head_settled <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next;
            s_ready      <= (count_next != CNT_FULL);
            head_settled <= (count != '0);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and per-state outputs; enable low holds the current state
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        core_x_ready = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        err_pulse    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && head_settled && (count != '0)) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                core_x_ready = 1'b1;
                if (enable) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (enable) begin
                    if (core_out_ready) begin
                        state_next = EMIT;
                    end else if (watchdog == WD_MAX) begin
                        state_next = ERR;
                    end
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                m_last  = !mode_run || (steps_left == 8'd1);
                if (enable && m_ready) begin
                    state_next = (mode_run && steps_left > 8'd1) ? ISSUE : IDLE;
                end
            end
            ERR: begin
                err_pulse = 1'b1;
                if (enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // run datapath: sample/prediction registers, step count, watchdog, error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg       <= '0;
            y_reg       <= '0;
            steps_left  <= '0;
            watchdog    <= '0;
            mode_run    <= 1'b0;
            timeout_err <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        x_reg      <= mem[rd_ptr];
                        mode_run   <= mode;
                        steps_left <= mode ? ((horizon == 8'd0) ? 8'd1 : horizon) : 8'd1;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                end
                WAIT: begin
                    if (core_out_ready) begin
                        y_reg <= core_y;
                    end else begin
                        watchdog <= watchdog + WDW'(1);
                    end
                end
                EMIT: begin
                    if (m_ready && mode_run && steps_left > 8'd1) begin
                        x_reg      <= y_reg;
                        steps_left <= steps_left - 8'd1;
                    end
                end
                ERR: begin
                    timeout_err <= 1'b1;
                    steps_left  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_narnet_seq_ctrl.sv
// Scoreboard bench for narnet_seq_ctrl: a reference model predicts the core
// inputs and the prediction stream for every pushed sample; monitor processes
// compare whatever the DUT presents against those queues.
module tb_narnet_seq_ctrl;

    localparam int N  = 10;
    localparam int TO = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         mode = 1'b0;
    logic [7:0]   horizon = 8'd0;
    logic         s_valid = 1'b0;
    logic [N-1:0] s_data = '0;
    logic         s_ready;
    logic         core_enable, core_rst;
    logic [N-1:0] core_x;
    logic         core_x_ready;
    logic [N-1:0] core_y = '0;
    logic         core_out_ready = 1'b0;
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_last;
    logic         m_ready = 1'b0;
    logic         busy, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [N-1:0] exp_cx [$];
    logic [N:0]   exp_out [$];
    int           plan_q [$];
    int           core_k = 1;
    bit           hold_mr = 1'b0;
    int           n_issue = 0;
    int           acc_cyc = 0;
    int           cor_cyc = 0;

    logic         prev_cxr = 1'b0, prev_mv = 1'b0, prev_acc = 1'b0;
    logic [N-1:0] prev_md = '0;

    narnet_seq_ctrl #(.N(N), .Q(8), .FIFO_DEPTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .horizon(horizon),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_enable(core_enable), .core_rst(core_rst),
        .core_x(core_x), .core_x_ready(core_x_ready),
        .core_y(core_y), .core_out_ready(core_out_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a sample x with core reply delay d (<0 = core silent).
    // Open loop: one core request x, one output x+k marked last.
    // Closed loop: max(horizon,1) requests x, x+k, x+2k..., outputs shifted by k.
    // A silent core yields the first request only and no output.
    task automatic push(input logic [N-1:0] x, input int d);
        logic [N-1:0] v;
        int h;
        int t;
        if (d < 0) begin
            exp_cx.push_back(x);
            plan_q.push_back(d);
        end else begin
            h = (mode == 1'b0) ? 1 : ((horizon == 8'd0) ? 1 : int'(horizon));
            v = x;
            for (int i = 0; i < h; i++) begin
                exp_cx.push_back(v);
                plan_q.push_back(d);
                v = v + N'(core_k);
                exp_out.push_back({(i == h - 1), v});
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = x;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_ready && t < 3000);
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_accept timed out actual=0 required=1");
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_ev(input int which, input int limit, output int c);
        int t = 0;
        bit hit = 1'b0;
        while (!hit && t < limit) begin
            @(negedge clk);
            t++;
            case (which)
                0:       hit = core_x_ready;
                1:       hit = core_rst;
                default: hit = m_valid;
            endcase
        end
        c = cyc;
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_event_%0d timed out actual=0 required=1", which);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_out.size() != 0 || exp_cx.size() != 0 || busy) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("drain_complete", (t < 6000), 1);
    endtask

    task automatic enable_dip();
        repeat (15) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b1;
    endtask

    // core model: answers each strobe after d enabled cycles with core_x + k
    initial begin : core_model
        int d;
        int n;
        logic [N-1:0] xv;
        forever begin
            @(negedge clk);
            if (core_x_ready && !rst) begin
                xv = core_x;
                d  = (plan_q.size() == 0) ? -1 : plan_q.pop_front();
                if (d > 0) begin
                    n = 0;
                    while (n < d) begin
                        @(posedge clk); #2;
                        if (core_enable) n++;
                    end
                    core_y = xv + N'(core_k);
                    core_out_ready = 1'b1;
                    @(posedge clk); #2;
                    core_out_ready = 1'b0;
                end
            end
        end
    end

    // random output backpressure unless held low
    initial begin : sink
        forever begin
            @(posedge clk); #1;
            m_ready = hold_mr ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: checks core requests and the output stream against the model
    initial begin : monitor
        logic [N:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cxr = 1'b0;
                prev_mv  = 1'b0;
                prev_acc = 1'b0;
            end else begin
                if (core_out_ready) cor_cyc = cyc;
                if (core_x_ready && !prev_cxr) begin
                    n_issue++;
                    if (exp_cx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue core_x=%0h required=none", core_x);
                    end else begin
                        check("core_x", core_x, exp_cx.pop_front());
                    end
                end
                if (m_valid && !prev_mv) check("m_valid_latency", cyc, cor_cyc + 1);
                if (m_valid && prev_mv && !prev_acc) check("m_data_stable", m_data, prev_md);
                prev_acc = m_valid && m_ready && enable;
                if (prev_acc) begin
                    if (exp_out.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output m_data=%0h required=none", m_data);
                    end else begin
                        e = exp_out.pop_front();
                        check("m_data", m_data, e[N-1:0]);
                        check("m_last", m_last, e[N]);
                    end
                end
                prev_cxr = core_x_ready;
                prev_mv  = m_valid;
                prev_md  = m_data;
            end
        end
    end

    initial begin : guard
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int c, c2, n0, bad;
        logic [N-1:0] x0;

        repeat (3) @(negedge clk);
        check("rst_core_rst", core_rst, 1);
        check("rst_outputs", {s_ready, core_x_ready, m_valid, m_last, busy, timeout_err}, 6'b0);
        check("rst_data", {core_x, m_data}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);
        check("core_rst_released", core_rst, 0);

        // issue latency from an idle, empty FIFO
        mode = 1'b0;
        core_k = 1;
        push(10'h055, 3);
        wait_ev(0, 50, c);
        check("issue_latency", c - acc_cyc, 3);
        drain();

        // open loop, three samples, slow core
        n0 = n_issue;
        push(10'h060, 40);
        push(10'h080, 40);
        push(10'h0A0, 40);
        drain();
        check("open_loop_issues", n_issue - n0, 3);

        // closed loop, horizon 4, y = x + 1
        mode = 1'b1;
        horizon = 8'd4;
        n0 = n_issue;
        push(10'h060, 5);
        drain();
        check("closed_loop_issues", n_issue - n0, 4);

        // horizon 0 behaves as 1
        horizon = 8'd0;
        n0 = n_issue;
        push(10'h100, 7);
        drain();
        check("horizon0_issues", n_issue - n0, 1);

        // randomized phases
        for (int p = 0; p < 6; p++) begin
            mode    = 1'($urandom_range(0, 1));
            horizon = 8'($urandom_range(0, 5));
            core_k  = $urandom_range(1, 50);
            for (int s = 0; s < int'($urandom_range(1, 4)); s++) begin
                push(N'($urandom), $urandom_range(1, 20));
            end
            drain();
        end

        // output backpressure: prediction held, FIFO fills, no new request
        mode = 1'b0;
        core_k = 3;
        hold_mr = 1'b1;
        x0 = N'($urandom);
        push(x0, 10);
        wait_ev(2, 200, c);
        n0 = n_issue;
        for (int s = 0; s < 8; s++) push(N'($urandom), 10);
        while (cyc < c + 20) @(negedge clk);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, x0 + N'(3));
        check("bp_s_ready_full", s_ready, 0);
        check("bp_no_issue", n_issue - n0, 0);
        hold_mr = 1'b0;
        drain();

        // reply arriving in the watchdog's final cycle still wins
        core_k = 1;
        push(10'h1F0, TO + 1);
        drain();
        check("boundary_no_timeout", timeout_err, 0);

        // silent core: abort at watchdog limit, next sample served normally
        push(10'h0C0, -1);
        wait_ev(0, 50, c);
        push(10'h0D0, 12);
        wait_ev(1, 400, c2);
        check("timeout_cycles", c2 - c, TO + 2);
        @(negedge clk);
        check("core_rst_one_cycle", core_rst, 0);
        check("timeout_err_set", timeout_err, 1);
        drain();

        // enable low mid-WAIT freezes the watchdog
        push(10'h0E0, -1);
        wait_ev(0, 50, c);
        enable_dip();
        wait_ev(1, 400, c2);
        check("timeout_with_dip", c2 - c, TO + 2 + 10);
        drain();

        // enable low mid-WAIT with a responsive core resumes the run
        mode = 1'b1;
        horizon = 8'd2;
        push(10'h033, 40);
        wait_ev(0, 50, c);
        enable_dip();
        drain();

        // reset during WAIT: back to IDLE, queued sample discarded
        mode = 1'b0;
        push(10'h011, -1);
        wait_ev(0, 50, c);
        push(10'h022, -1);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_core_rst", core_rst, 1);
        check("rst_mid_flags", {busy, s_ready, m_valid, timeout_err}, 4'b0);
        exp_cx.delete();
        exp_out.delete();
        plan_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_s_ready", s_ready, 1);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) bad++;
        end
        check("rst_mid_fifo_empty", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/narnet_seq_ctrl.md
NARNET_SEQ_CTRL -- requirements
Module: narnet_seq_ctrl

Interface
REQ-001 Parameter N, default 10: sample/prediction width, signed fixed point.
REQ-002 Parameter Q, default 8: fractional bits; informational only, no arithmetic here.
REQ-003 Parameter FIFO_DEPTH, default 8: input FIFO entries; power of 2, at least 2.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  global run; low freezes the FSM, counters and FIFO pops.
REQ-008 mode  in  1  0 = open-loop (one host sample per prediction); 1 = closed-loop (seed, then feedback).
REQ-009 horizon  in  8  closed-loop step count; 0 treated as 1.
REQ-010 s_valid / s_data / s_ready  in 1 / in N / out 1  host sample stream, valid/ready.
REQ-011 core_enable  out  1  drives NAR core enable.
REQ-012 core_rst  out  1  drives NAR core rst.
REQ-013 core_x / core_x_ready  out N / out 1  sample and strobe to the core.
REQ-014 core_y / core_out_ready  in N / in 1  core prediction and its one-cycle done pulse.
REQ-015 m_valid / m_data / m_last / m_ready  out 1 / out N / out 1 / in 1  prediction stream, valid/ready.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 timeout_err  out  1  sticky watchdog flag.

Function
REQ-018 Input FIFO: s_ready = not full (registered); push on s_valid && s_ready; a push and a pop in the same cycle are both honoured; the FIFO is never read when empty.
REQ-019 States: IDLE, ISSUE, WAIT, EMIT, ERR.
REQ-020 IDLE -> ISSUE when enable && FIFO non-empty; the head is popped into x_reg; mode is latched; steps_left = max(horizon,1) in closed-loop, 1 in open-loop.
REQ-021 ISSUE: core_x = x_reg, core_x_ready = 1 for exactly one cycle; watchdog cleared; next state WAIT.
REQ-022 WAIT: watchdog increments each enabled cycle; on core_out_ready, core_y is captured into y_reg and the FSM goes to EMIT.
REQ-023 WAIT: when the watchdog reaches TIMEOUT without core_out_ready, go to ERR; core_out_ready in the same cycle as TIMEOUT wins (go to EMIT).
REQ-024 EMIT: m_valid = 1 and m_data = y_reg, both held stable until m_ready; m_last = 1 in open-loop, or in closed-loop when steps_left == 1.
REQ-025 EMIT accept: closed-loop with steps_left > 1 -> x_reg = y_reg, steps_left decrements, next state ISSUE; otherwise IDLE.
REQ-026 ERR: core_rst = 1 for one cycle; timeout_err set; in-flight step and remaining closed-loop steps discarded (FIFO kept); next state IDLE.
REQ-027 core_enable = enable; core_rst = rst OR ERR pulse.
REQ-028 core_out_ready outside WAIT is ignored.
REQ-029 mode/horizon changes during a run take effect only at the next IDLE exit.
REQ-030 enable low: state, watchdog, steps_left and outputs hold; FIFO pushes continue.
REQ-031 Latency: sample accepted at cycle t -> core_x_ready at t+3 earliest; core_out_ready at cycle u -> m_valid at u+1.
REQ-032 Throughput: at most one outstanding core request; no new ISSUE before the prior EMIT is accepted.

Reset
REQ-033 While rst is high: state IDLE; FIFO emptied; s_ready 0 (1 the cycle after rst falls); core_x_ready, m_valid, m_last, busy and timeout_err are 0; core_x, m_data, x_reg, y_reg, steps_left and watchdog are 0; core_rst is 1.
REQ-034 rst mid-run aborts immediately, with no m_valid emitted for the in-flight step.

Verification
REQ-035 Open-loop: push 3 samples (0x060, 0x080, 0x0A0); core model replies in 40 cycles -> 3 core_x_ready pulses in order, 3 outputs, each with m_last = 1.
REQ-036 Closed-loop, horizon = 4, seed 0x060, model y = x + 1 -> core_x sequence 0x060, 0x061, 0x062, 0x063; m_data sequence 0x061..0x064; m_last only on 0x064.
REQ-037 Backpressure: m_ready low for 20 cycles in EMIT -> m_data stable, no new core_x_ready; FIFO fills to 8 and s_ready drops.
REQ-038 Timeout: core model never responds -> ERR entered at watchdog = 255, one-cycle core_rst, timeout_err = 1; next FIFO sample is then issued normally.
REQ-039 Edge cases: horizon = 0 gives a single output; core_out_ready in the TIMEOUT cycle goes to EMIT; rst asserted in WAIT returns to IDLE with FIFO empty.
REQ-040 Enable gating: enable low for 10 cycles mid-WAIT -> watchdog frozen; FSM resumes correctly when enable returns.
